// File: rtl/nsa_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package nsa_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead adder slice.
module cla4_slice
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
    output logic [NIB_W-1:0] sum,
    output logic             c_out
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < int'(NIB_W); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c[NIB_W-1:0];
    assign c_out = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per cycle through a single CLA slice.
// Optional signed-overflow output enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    nsa_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_c;
    logic             last;
    logic             accept;

    assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign last     = (idx == IDX_W'(NIBBLES - 1));

    // Select the current operand nibbles with constant part-selects.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    cla4_slice u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < int'(NIBBLES); i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[i*NIB_W +: NIB_W] <= slice_sum;
                        end
                    end
                    carry <= slice_c;
                    if (last) begin
                        c_out     <= slice_c;
                        out_valid <= 1'b1;
`ifdef NSA_OVERFLOW_EN
                        ovf       <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1])
                                   & (a_q[WIDTH-1] ^ slice_sum[NIB_W-1]);
`endif
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; back-to-back accept allowed.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            a_q   <= a;
                            b_q   <= b;
                            carry <= c_in;
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances).
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out;
    logic [15:0] a, b, sum;
    logic        ovf;

    logic        in_valid4, in_ready4, c_in4, out_valid4, c_out4;
    logic [3:0]  a4, b4, sum4;
    logic        ovf4;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef NSA_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .c_in(c_in4), .out_valid(out_valid4), .out_ready(1'b1),
        .sum(sum4), .c_out(c_out4)
`ifdef NSA_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

`ifndef NSA_OVERFLOW_EN
    assign ovf  = 1'b0;
    assign ovf4 = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb, input logic ci);
        a = xa; b = xb; c_in = ci; in_valid = 1'b1;
    endtask

    // Counts edges from the acceptance edge (edge 1) until out_valid, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            in_valid = 1'b0;
            if (out_valid) break;
        end
    endtask

    initial begin
        int n;
        int stale;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_c_out", 32'(c_out), 0);
        check("rst_sum4", 32'(sum4), 0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci);
            wait_result(n);
            check($sformatf("v%0d_latency", i), 32'(n), 5);
            check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("v%0d_c_out", i), 32'(c_out), 32'(vecs[i].co));
`ifdef NSA_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
`endif
        end

        // Back-pressure: hold result for 10 cycles with a pending operand pair.
        @(posedge clk); #1;
        out_ready = 1'b0;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_result(n);
        check("bp_first_latency", 32'(n), 5);
        start_op(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_sum", 32'(sum), 32'h5555);
            check("bp_c_out", 32'(c_out), 0);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 1);
        wait_result(n);
        check("bp_next_latency", 32'(n), 5);
        check("bp_next_sum", 32'(sum), 32'h0000);
        check("bp_next_c_out", 32'(c_out), 1);

        // Reset asserted for one edge while idx=2.
        start_op(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_sum", 32'(sum), 0);
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("post_rst_no_stale", 32'(stale), 0);
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_result(n);
        check("post_rst_latency", 32'(n), 5);
        check("post_rst_result", 32'(sum), 32'h5555);

        // WIDTH=4 instance: 0x9 + 0x8 + 1.
        @(posedge clk); #1;
        a4 = 4'h9; b4 = 4'h8; c_in4 = 1'b1; in_valid4 = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            in_valid4 = 1'b0;
            if (out_valid4) break;
        end
        check("w4_latency", 32'(n), 2);
        check("w4_sum", 32'(sum4), 32'h2);
        check("w4_c_out", 32'(c_out4), 1);
`ifdef NSA_OVERFLOW_EN
        check("w4_ovf", 32'(ovf4), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
